// File: rtl/timer_pkg.sv
// Shared type definitions for the down-counting timer.
package timer_pkg;

  // Controller states; encoding is left to the enum.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  // Behaviour when the count reaches zero.
  typedef enum logic {
    ONE_SHOT = 1'b0,
    PERIODIC = 1'b1
  } mode_t;

endpackage

// File: rtl/down_timer_if.sv
// Load handshake and status bundle for down_timer.
interface down_timer_if #(
  parameter int unsigned MAX_COUNT = 255
);
  localparam int unsigned W = (MAX_COUNT < 1) ? 1 : $clog2(MAX_COUNT + 1);

  logic         load_valid;
  logic         load_ready;
  logic [W-1:0] load_value;
  logic         load_periodic;
  logic         pause;
  logic         abort;
  logic [W-1:0] count;
  logic         busy;
  logic         expired;

  // Requester side: issues loads and control, observes status.
  modport master (
    output load_valid, load_value, load_periodic, pause, abort,
    input  load_ready, count, busy, expired
  );

  // Timer side.
  modport slave (
    input  load_valid, load_value, load_periodic, pause, abort,
    output load_ready, count, busy, expired
  );
endinterface

// File: rtl/down_timer.sv
// Loadable down-counter with one-shot / auto-reload modes, pause and abort.
module down_timer
  import timer_pkg::*;
#(
  parameter int unsigned MAX_COUNT = 255
) (
  input  logic       clk,
  input  logic       reset,
  down_timer_if.slave bus
);

  localparam int unsigned W = (MAX_COUNT < 1) ? 1 : $clog2(MAX_COUNT + 1);
  localparam logic [W-1:0] MAX_W = W'(MAX_COUNT);

  state_t       state_q, state_d;
  mode_t        mode_q, mode_d;
  logic [W-1:0] count_q, count_d;
  logic [W-1:0] reload_q, reload_d;
  logic         expired_q, expired_d;
  logic         busy_q;
  logic         load_ready_c;
  logic [W-1:0] load_sat;

  // Clamp an oversized load to the largest legal count.
  assign load_sat = (bus.load_value > MAX_W) ? MAX_W : bus.load_value;

  // State and datapath registers; reset discards any operation in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      mode_q    <= ONE_SHOT;
      count_q   <= '0;
      reload_q  <= '0;
      expired_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mode_q    <= mode_d;
      count_q   <= count_d;
      reload_q  <= reload_d;
      expired_q <= expired_d;
      busy_q    <= (state_d != ST_IDLE);
    end
  end

  // Next state: abort wins; a released pause acts like a running cycle.
  always_comb begin
    state_d = state_q;
    if (bus.abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.load_valid) state_d = ST_RUN;
        end
        ST_RUN, ST_PAUSE: begin
          if (bus.pause)
            state_d = ST_PAUSE;
          else if ((count_q == '0) && (mode_q == ONE_SHOT))
            state_d = ST_IDLE;
          else
            state_d = ST_RUN;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Datapath next values, expiry pulse and load acceptance.
  always_comb begin
    count_d      = count_q;
    reload_d     = reload_q;
    mode_d       = mode_q;
    expired_d    = 1'b0;
    load_ready_c = (state_q == ST_IDLE) && !bus.abort;
    if (bus.abort) begin
      count_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.load_valid) begin
            count_d  = load_sat;
            reload_d = load_sat;
            mode_d   = bus.load_periodic ? PERIODIC : ONE_SHOT;
          end
        end
        ST_RUN, ST_PAUSE: begin
          if (!bus.pause) begin
            if (count_q != '0) begin
              count_d = count_q - W'(1);
            end else begin
              expired_d = 1'b1;
              if (mode_q == PERIODIC) count_d = reload_q;
            end
          end
        end
        default: begin
          count_d = '0;
        end
      endcase
    end
  end

  assign bus.load_ready = load_ready_c;
  assign bus.count      = count_q;
  assign bus.busy       = busy_q;
  assign bus.expired    = expired_q;

endmodule

// File: tb/tb_down_timer.sv
// Randomized and directed bench for down_timer against a behavioural model.
module tb_down_timer;
  localparam int unsigned MC = 200;
  localparam int unsigned W  = $clog2(MC + 1);

  logic clk   = 1'b0;
  logic reset = 1'b1;

  int n_cmp = 0;
  int n_mis = 0;

  // Behavioural model: remaining count, reload, mode, activity, pulse.
  int m_count    = 0;
  int m_reload   = 0;
  bit m_busy     = 1'b0;
  bit m_periodic = 1'b0;
  bit m_expired  = 1'b0;

  down_timer_if #(.MAX_COUNT(MC)) bus ();

  down_timer #(.MAX_COUNT(MC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // One clock of the timer's rules, in plain arithmetic.
  task automatic model_step();
    int v;
    if (reset) begin
      m_count = 0; m_reload = 0; m_busy = 0; m_periodic = 0; m_expired = 0;
    end else begin
      m_expired = 0;
      if (bus.abort) begin
        m_busy  = 0;
        m_count = 0;
      end else if (!m_busy) begin
        if (bus.load_valid) begin
          v = int'(bus.load_value);
          if (v > int'(MC)) v = int'(MC);
          m_count    = v;
          m_reload   = v;
          m_periodic = bus.load_periodic;
          m_busy     = 1;
        end
      end else if (!bus.pause) begin
        if (m_count > 0) begin
          m_count = m_count - 1;
        end else begin
          m_expired = 1;
          if (m_periodic) m_count = m_reload;
          else m_busy = 0;
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk or posedge reset);
    model_step();
  end

  // Every-cycle comparison against the model.
  initial forever begin
    @(negedge clk);
    chk("cmp_count",   int'(bus.count),      m_count);
    chk("cmp_busy",    int'(bus.busy),       int'(m_busy));
    chk("cmp_expired", int'(bus.expired),    int'(m_expired));
    chk("cmp_ready",   int'(bus.load_ready), int'(!m_busy && !bus.abort));
  end

  task automatic cyc(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic look(input string nm, input int c, input int b, input int e);
    @(negedge clk);
    chk({nm, ".count"},   int'(bus.count),   c);
    chk({nm, ".busy"},    int'(bus.busy),    b);
    chk({nm, ".expired"}, int'(bus.expired), e);
  endtask

  task automatic do_load(input int v, input bit per);
    bus.load_valid    = 1'b1;
    bus.load_value    = W'(v);
    bus.load_periodic = per;
    cyc();
    bus.load_valid = 1'b0;
  endtask

  initial begin
    bus.load_valid = 0; bus.load_value = '0; bus.load_periodic = 0;
    bus.pause = 0; bus.abort = 0;
    cyc(2);
    reset = 1'b0;
    look("rst", 0, 0, 0);
    chk("rst.ready", int'(bus.load_ready), 1);

    // One-shot load 3.
    cyc();
    do_load(3, 1'b0);
    for (int k = 3; k >= 0; k--) begin
      look("os3", k, 1, 0);
      cyc();
    end
    look("os3_exp", 0, 0, 1);
    chk("os3_ready", int'(bus.load_ready), 1);
    cyc();
    look("os3_after", 0, 0, 0);

    // Periodic load 2: pulse every third cycle, then abort.
    cyc();
    do_load(2, 1'b1);
    look("per_start", 2, 1, 0);
    for (int p = 0; p < 4; p++) begin
      cyc(); look("per_1", 1, 1, 0);
      cyc(); look("per_0", 0, 1, 0);
      cyc(); look("per_exp", 2, 1, 1);
    end
    cyc();
    bus.abort = 1'b1;
    look("per_preabort", 1, 1, 0);
    chk("per_abort_ready", int'(bus.load_ready), 0);
    cyc();
    bus.abort = 1'b0;
    look("per_abort", 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(); look("per_quiet", 0, 0, 0);
    end

    // One-shot 5 with a four-cycle pause at count 2.
    cyc();
    do_load(5, 1'b0);
    look("pz5", 5, 1, 0);
    cyc(); look("pz4", 4, 1, 0);
    cyc(); look("pz3", 3, 1, 0);
    cyc();
    bus.pause = 1'b1;
    look("pz2", 2, 1, 0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      if (i == 3) bus.pause = 1'b0;
      look("pz_hold", 2, 1, 0);
    end
    cyc(); look("pz_res1", 1, 1, 0);
    cyc(); look("pz_res0", 0, 1, 0);
    cyc(); look("pz_exp", 0, 0, 1);

    // Pause held at count 0 suppresses expiry until release.
    cyc();
    do_load(1, 1'b0);
    look("pz0_1", 1, 1, 0);
    cyc();
    bus.pause = 1'b1;
    look("pz0_0", 0, 1, 0);
    cyc(); look("pz0_hold", 0, 1, 0);
    cyc();
    bus.pause = 1'b0;
    look("pz0_hold2", 0, 1, 0);
    cyc(); look("pz0_exp", 0, 0, 1);

    // Saturation, ignored load while busy, abort beats load in idle.
    cyc();
    do_load(250, 1'b0);
    look("sat", 200, 1, 0);
    cyc();
    bus.load_valid = 1'b1; bus.load_value = W'(7);
    look("busy_ld", 199, 1, 0);
    cyc();
    bus.load_valid = 1'b0;
    look("busy_ld2", 198, 1, 0);
    cyc();
    bus.abort = 1'b1;
    look("ab_pre", 197, 1, 0);
    cyc();
    bus.load_valid = 1'b1; bus.load_value = W'(9);
    look("ab_idle", 0, 0, 0);
    chk("ab_idle.ready", int'(bus.load_ready), 0);
    cyc();
    bus.abort = 1'b0; bus.load_valid = 1'b0;
    look("ab_noload", 0, 0, 0);

    // Asynchronous reset between edges, then periodic reload 0.
    cyc();
    do_load(50, 1'b0);
    cyc(3);
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("arst.count",   int'(bus.count),   0);
    chk("arst.busy",    int'(bus.busy),    0);
    chk("arst.expired", int'(bus.expired), 0);
    @(posedge clk);
    #1 reset = 1'b0;
    look("arst_rel", 0, 0, 0);
    chk("arst_rel.ready", int'(bus.load_ready), 1);
    cyc();
    do_load(0, 1'b1);
    look("p0_start", 0, 1, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(); look("p0_pulse", 0, 1, 1);
    end
    cyc();
    bus.abort = 1'b1;
    cyc();
    bus.abort = 1'b0;

    // Randomized traffic checked by the every-cycle compare.
    for (int i = 0; i < 600; i++) begin
      cyc();
      bus.load_valid    = ($urandom_range(0, 99) < 30);
      bus.load_value    = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 255))
                                                      : W'($urandom_range(0, 7));
      bus.load_periodic = ($urandom_range(0, 1) == 1);
      bus.pause         = ($urandom_range(0, 99) < 15);
      bus.abort         = ($urandom_range(0, 99) < 3);
    end
    cyc();
    bus.load_valid = 0; bus.pause = 0; bus.abort = 0;
    cyc(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/down_timer.md
DOWN_TIMER -- requirements
Module: down_timer

Interface
REQ-001 Parameter MAX_COUNT, default 255: largest loadable count; W = ceil(log2(MAX_COUNT+1)), minimum 1.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 reset  in  1  asynchronous, active-high reset.
REQ-004 load_valid  in  1  load request qualifier.
REQ-005 load_ready  out  1  timer accepts a load this cycle.
REQ-006 load_value  in  W  initial/reload count.
REQ-007 load_periodic  in  1  1 = auto-reload mode, 0 = one-shot; sampled with load.
REQ-008 pause  in  1  freeze countdown while high.
REQ-009 abort  in  1  cancel operation, return to IDLE.
REQ-010 count  out  W  current remaining count, registered.
REQ-011 busy  out  1  high when state is not IDLE.
REQ-012 expired  out  1  one-cycle registered terminal-count pulse.

Function
REQ-013 States SHALL be IDLE, RUN, PAUSE; encoding is free.
REQ-014 load_ready SHALL equal (state == IDLE) AND NOT abort; it is combinational from state and abort only, never from load_valid.
REQ-015 A load SHALL be accepted on an edge with load_valid AND load_ready: count and reload register <= load_value, mode <= load_periodic, state -> RUN.
REQ-016 load_value above MAX_COUNT SHALL saturate to MAX_COUNT in both count and reload register.
REQ-017 In RUN with pause low and count > 0, count SHALL decrement by 1 per edge.
REQ-018 In RUN with pause low and count == 0: expired <= 1 on that edge; one-shot -> IDLE, count stays 0; periodic -> count <= reload value, stay RUN.
REQ-019 expired SHALL be 0 on every other edge; no back-to-back pulses except periodic reload value 0, which pulses every cycle.
REQ-020 Latency: load N accepted at edge E -> expired high in the cycle after edge E+N+1; periodic period = N+1 cycles.
REQ-021 In RUN with pause high: state -> PAUSE, count held, including when count == 0 (no expiry while paused).
REQ-022 In PAUSE: count held; pause low -> RUN on next edge, countdown resumes from held value.
REQ-023 abort high at an edge, from any state: state -> IDLE, count <= 0, expired <= 0; abort beats load, pause and expiry.
REQ-024 load_valid outside IDLE SHALL be ignored; no queuing; a new load is possible the cycle after a one-shot returns to IDLE.
REQ-025 Count SHALL never wrap below 0 nor exceed MAX_COUNT.
REQ-026 busy SHALL be derived from the registered state, with no combinational path from inputs.

Reset
REQ-027 reset high SHALL immediately force state IDLE, count 0, expired 0, busy 0, reload register 0, mode one-shot, regardless of clk.
REQ-028 Reset mid-RUN or mid-PAUSE SHALL discard the operation; after release the timer waits in IDLE with load_ready high.

Structure
REQ-029 A shared package timer_pkg SHALL hold the state enum type and the mode enum (ONE_SHOT, PERIODIC).
REQ-030 W SHALL be computed locally from MAX_COUNT.
REQ-031 The design SHALL be one module with no sub-module; the FSM, count register and reload register stay together.

Verification
REQ-032 MAX_COUNT=255, one-shot load 3 -> count 3,2,1,0; expired one cycle at load edge+4; busy falls with it; load_ready returns high.
REQ-033 Periodic load 2 -> expired every 3 cycles for 4 periods; then abort -> IDLE, count 0, no further pulses.
REQ-034 One-shot load 5, pause high for 4 cycles when count==2 -> count holds 2; expiry delayed exactly 4 cycles; pause asserted at count 0 suppresses expiry until release.
REQ-035 MAX_COUNT=200, load 250 -> count 200; load_valid while busy -> ignored, count unaffected; abort with load_valid in IDLE -> load_ready 0, no load.
REQ-036 Async reset pulse mid-RUN between clock edges -> outputs 0 immediately; periodic load 0 after release -> expired high every cycle.
